// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between the core's
// instruction-fetch and data-access sides. One transaction at a time runs
// through IDLE -> ADDR -> DATA -> RESP. Data wins arbitration unless fetch
// has been passed over STARVE_MAX times in a row. A transaction that stays
// too long in ADDR/DATA is aborted and completes with bus_err.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  output logic        inst_ok_o,
  output logic [31:0] inst_rdata_o,
  input  logic        data_req_i,
  input  logic [3:0]  data_wen_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_ok_o,
  output logic [31:0] data_rdata_o,
  output logic        bus_err_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_addr_ok_i,
  input  logic        mem_data_ok_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TCNT_LAST  = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic STARVE_EN  = (STARVE_MAX != 0);
  localparam logic TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          side_q, side_d;         // 1 = data side granted
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    wen_q, wen_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;
  logic [31:0]   inst_rdata_q, inst_rdata_d;
  logic [31:0]   data_rdata_q, data_rdata_d;
  logic          mem_req_q, mem_req_d;
  logic          inst_ok_q, inst_ok_d;
  logic          data_ok_q, data_ok_d;
  logic          bus_err_q, bus_err_d;

  logic          force_inst_s;
  logic          grant_data_s;
  logic          timeout_hit_s;

  // Fetch is forced to win only once it has been passed over STARVE_MAX times.
  assign force_inst_s  = STARVE_EN & inst_req_i & (starve_q == STARVE_TOP);
  assign grant_data_s  = data_req_i & ~force_inst_s;
  assign timeout_hit_s = TIMEOUT_EN & (tcnt_q == TCNT_LAST);

  // Next-state, latched-request, counter and read-data capture logic.
  always_comb begin
    state_d      = state_q;
    side_d       = side_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    starve_d     = starve_q;
    tcnt_d       = tcnt_q;
    err_d        = err_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (inst_req_i | data_req_i) begin
          side_d  = grant_data_s;
          addr_d  = grant_data_s ? data_addr_i  : inst_addr_i;
          wen_d   = grant_data_s ? data_wen_i   : 4'b0000;
          wdata_d = grant_data_s ? data_wdata_i : 32'h0000_0000;
          wr_d    = grant_data_s & (data_wen_i != 4'b0000);
          err_d   = 1'b0;
          tcnt_d  = {TW{1'b0}};
          state_d = S_ADDR;
          if (grant_data_s & inst_req_i) begin
            if (starve_q != STARVE_TOP) begin
              starve_d = starve_q + SW'(1);
            end else begin
              starve_d = starve_q;
            end
          end else begin
            starve_d = {SW{1'b0}};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (timeout_hit_s) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (mem_addr_ok_i) begin
          tcnt_d  = tcnt_q + TW'(1);
          state_d = S_DATA;
        end else begin
          tcnt_d  = tcnt_q + TW'(1);
        end
      end
      S_DATA: begin
        if (mem_data_ok_i) begin
          if (!side_q) begin
            inst_rdata_d = mem_rdata_i;
          end else if (wen_q == 4'b0000) begin
            data_rdata_d = mem_rdata_i;
          end else begin
            data_rdata_d = data_rdata_q;
          end
          state_d = S_RESP;
        end else if (timeout_hit_s) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          tcnt_d  = tcnt_q + TW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered output values derived from the upcoming state.
  always_comb begin
    mem_req_d = (state_d == S_ADDR);
    inst_ok_d = (state_d == S_RESP) & ~side_d;
    data_ok_d = (state_d == S_RESP) & side_d;
    bus_err_d = (state_d == S_RESP) & err_d;
  end

  // State and output registers; reset returns to IDLE with everything cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      side_q       <= 1'b0;
      addr_q       <= 32'h0000_0000;
      wen_q        <= 4'b0000;
      wdata_q      <= 32'h0000_0000;
      wr_q         <= 1'b0;
      starve_q     <= {SW{1'b0}};
      tcnt_q       <= {TW{1'b0}};
      err_q        <= 1'b0;
      inst_rdata_q <= 32'h0000_0000;
      data_rdata_q <= 32'h0000_0000;
      mem_req_q    <= 1'b0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      side_q       <= side_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      starve_q     <= starve_d;
      tcnt_q       <= tcnt_d;
      err_q        <= err_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      mem_req_q    <= mem_req_d;
      inst_ok_q    <= inst_ok_d;
      data_ok_q    <= data_ok_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign inst_ok_o    = inst_ok_q;
  assign data_ok_o    = data_ok_q;
  assign bus_err_o    = bus_err_q;
  assign inst_rdata_o = inst_rdata_q;
  assign data_rdata_o = data_rdata_q;
  assign mem_req_o    = mem_req_q;
  assign mem_wr_o     = wr_q;
  assign mem_wstrb_o  = wen_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;

  // Core stall: a side stalls while it requests and has not seen its ok.
  assign stall_o = (inst_req_i & ~inst_ok_q) | (data_req_i & ~data_ok_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a transaction-level timeline model predicts
// each grant, the memory-side request and the completion pulse; a negedge
// monitor pops the expected items and compares them with the DUT.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;
  localparam int TMO  = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_req, data_req, inst_ok, data_ok, bus_err, stall;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0]  data_wen, mem_wstrb;
  logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_ok_o(inst_ok), .inst_rdata_o(inst_rdata),
    .data_req_i(data_req), .data_wen_i(data_wen), .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_ok_o(data_ok), .data_rdata_o(data_rdata), .bus_err_o(bus_err), .stall_o(stall),
    .mem_req_o(mem_req), .mem_wr_o(mem_wr), .mem_wstrb_o(mem_wstrb), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_addr_ok_i(mem_addr_ok), .mem_data_ok_i(mem_data_ok),
    .mem_rdata_i(mem_rdata)
  );

  typedef struct {
    int          start;
    int          hold;
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        is_data;
  } mem_exp_t;

  typedef struct {
    int          cyc;
    logic        iok;
    logic        dok;
    logic        err;
    logic [31:0] irdata;
    logic [31:0] drdata;
  } ok_exp_t;

  mem_exp_t mem_q[$];
  ok_exp_t  ok_q[$];
  logic     obs_q[$];

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // requester state
  logic        ireq_v, dreq_v, i_busy, d_busy, i_granted, d_granted;
  logic [31:0] iaddr_v, daddr_v, dwdata_v;
  logic [3:0]  dwen_v;
  // model state
  int          free_cyc, starve, iok_cyc, dok_cyc;
  int          addr_lo, addr_hi, data_lo, data_hi, aok_at, dok_at, late1, late2;
  logic [31:0] m_ird, m_drd, rdata_at;
  logic        exp_stall, mon_en;
  // knobs
  logic        rand_mode, rd_fix_en;
  logic [31:0] rd_fix;
  int          p_i, p_d, p_flush, p_noise, max_a, max_d, fix_a, fix_d;
  int          mreq_cnt;
  logic [4:0]  exp_seq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_clear();
    mem_q.delete(); ok_q.delete();
    free_cyc = 0; starve = 0; iok_cyc = -1; dok_cyc = -1;
    addr_lo = -1; addr_hi = -2; data_lo = -1; data_hi = -2;
    aok_at = -1; dok_at = -1; late1 = -1; late2 = -1;
    m_ird = 32'h0; m_drd = 32'h0; rdata_at = 32'h0;
    ireq_v = 1'b0; dreq_v = 1'b0; i_busy = 1'b0; d_busy = 1'b0;
    i_granted = 1'b0; d_granted = 1'b0; exp_stall = 1'b0; mreq_cnt = 0;
  endtask

  // One transaction: pick winner, draw memory delays, predict its timeline.
  task automatic grant();
    int a, d, c, last;
    logic gd, abort;
    logic [31:0] rd;
    mem_exp_t me_n;
    ok_exp_t  oe_n;
    gd = dreq_v && !((SMAX != 0) && ireq_v && (starve == SMAX));
    if (gd) starve = ireq_v ? ((starve < SMAX) ? starve + 1 : starve) : 0;
    else    starve = 0;
    a = (fix_a >= 0) ? fix_a : int'($urandom_range(0, max_a));
    d = (fix_d >= 0) ? fix_d : int'($urandom_range(0, max_d));
    c = a + 1 + d;
    abort = (TMO != 0) && (c >= TMO);
    last = abort ? TMO - 1 : c;
    me_n.start = cyc + 1; me_n.hold = a + 1; me_n.is_data = gd;
    me_n.addr = gd ? daddr_v : iaddr_v;
    me_n.wr = gd && (dwen_v != 4'b0000);
    me_n.wstrb = dwen_v; me_n.wdata = dwdata_v;
    mem_q.push_back(me_n);
    rd = rd_fix_en ? rd_fix : 32'($urandom);
    aok_at = cyc + 1 + a; addr_lo = cyc + 1; addr_hi = cyc + 1 + a;
    data_lo = cyc + 2 + a; data_hi = cyc + 1 + last;
    if (!abort) begin
      dok_at = cyc + 2 + a + d; rdata_at = rd; late1 = -1; late2 = -1;
      if (!gd) m_ird = rd;
      else if (dwen_v == 4'b0000) m_drd = rd;
    end else begin
      dok_at = -1; late1 = cyc + 2 + last; late2 = cyc + 3 + last;
    end
    oe_n.cyc = cyc + 2 + last; oe_n.iok = !gd; oe_n.dok = gd; oe_n.err = abort;
    oe_n.irdata = m_ird; oe_n.drdata = m_drd;
    ok_q.push_back(oe_n);
    if (gd) begin dok_cyc = oe_n.cyc; d_granted = 1'b1; end
    else    begin iok_cyc = oe_n.cyc; i_granted = 1'b1; end
    free_cyc = cyc + 3 + last;
  endtask

  // Per-cycle requester behaviour, arbitration model and memory responder.
  task automatic step();
    if (iok_cyc == cyc - 1) begin i_busy = 1'b0; ireq_v = 1'b0; i_granted = 1'b0; end
    if (dok_cyc == cyc - 1) begin d_busy = 1'b0; dreq_v = 1'b0; d_granted = 1'b0; end
    if (rand_mode) begin
      if (!i_busy && int'($urandom_range(0, 99)) < p_i) begin
        ireq_v = 1'b1; i_busy = 1'b1; iaddr_v = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_busy && int'($urandom_range(0, 99)) < p_d) begin
        dreq_v = 1'b1; d_busy = 1'b1; daddr_v = $urandom; dwdata_v = $urandom;
        dwen_v = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      end
      if (i_granted && ireq_v && int'($urandom_range(0, 99)) < p_flush) ireq_v = 1'b0;
      if (d_granted && dreq_v && int'($urandom_range(0, 99)) < p_flush) dreq_v = 1'b0;
    end
    if (cyc >= free_cyc && (ireq_v || dreq_v)) grant();
    inst_req = ireq_v; inst_addr = iaddr_v;
    data_req = dreq_v; data_addr = daddr_v; data_wen = dwen_v; data_wdata = dwdata_v;
    mem_addr_ok = (cyc == aok_at) ||
                  (!(cyc >= addr_lo && cyc <= addr_hi) && int'($urandom_range(0, 99)) < p_noise);
    mem_data_ok = (cyc == dok_at) || (cyc == late1) || (cyc == late2) ||
                  (!(cyc >= data_lo && cyc <= data_hi) && int'($urandom_range(0, 99)) < p_noise);
    mem_rdata = (cyc == dok_at) ? rdata_at : 32'($urandom);
    exp_stall = (ireq_v && iok_cyc != cyc) || (dreq_v && dok_cyc != cyc);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      step();
    end
  endtask

  task automatic wait_quiet();
    int k = 0;
    while ((i_busy || d_busy || ok_q.size() != 0 || mem_q.size() != 0) && k < 400) begin
      run(1); k++;
    end
    if (k >= 400) chk("drain timeout pending ok", 32'(ok_q.size()), 32'd0);
  endtask

  task automatic req_inst(input logic [31:0] a);
    ireq_v = 1'b1; i_busy = 1'b1; i_granted = 1'b0; iaddr_v = a;
  endtask

  task automatic req_data(input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd);
    dreq_v = 1'b1; d_busy = 1'b1; d_granted = 1'b0; dwen_v = w; daddr_v = a; dwdata_v = wd;
  endtask

  // Scoreboard monitor: compares stall, memory-side request and ok pulses.
  always @(negedge clk) begin
    mem_exp_t me;
    ok_exp_t  oe;
    if (mon_en && rst_n) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      if (mem_req) begin
        if (mem_q.size() == 0) chk("mem_req unexpected", 32'(mem_req), 32'd0);
        else begin
          me = mem_q[0];
          if (mreq_cnt == 0) chk("mem_req start cycle", 32'(cyc), 32'(me.start));
          chk("mem_addr", mem_addr, me.addr);
          chk("mem_wr", 32'(mem_wr), 32'(me.wr));
          if (me.is_data) begin
            chk("mem_wstrb", 32'(mem_wstrb), 32'(me.wstrb));
            chk("mem_wdata", mem_wdata, me.wdata);
          end
          mreq_cnt++;
          if (mem_addr_ok) begin
            chk("mem_req hold cycles", 32'(mreq_cnt), 32'(me.hold));
            void'(mem_q.pop_front());
            mreq_cnt = 0;
          end
        end
      end
      while (ok_q.size() != 0 && ok_q[0].cyc < cyc) begin
        chk("ok pulse missing at cycle", 32'(cyc), 32'(ok_q[0].cyc));
        void'(ok_q.pop_front());
      end
      if (inst_ok || data_ok || bus_err) begin
        if (ok_q.size() == 0) chk("ok unexpected", {29'd0, inst_ok, data_ok, bus_err}, 32'd0);
        else begin
          oe = ok_q.pop_front();
          chk("ok cycle", 32'(cyc), 32'(oe.cyc));
          chk("ok flags inst/data/err", {29'd0, inst_ok, data_ok, bus_err},
              {29'd0, oe.iok, oe.dok, oe.err});
          chk("inst_rdata", inst_rdata, oe.irdata);
          chk("data_rdata", data_rdata, oe.drdata);
          obs_q.push_back(data_ok);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    mon_en = 1'b0; rst_n = 1'b0;
    model_clear();
    rand_mode = 1'b0; rd_fix_en = 1'b0; rd_fix = 32'h0;
    p_i = 0; p_d = 0; p_flush = 0; p_noise = 0; max_a = 0; max_d = 0; fix_a = 0; fix_d = 0;
    iaddr_v = 32'h0; daddr_v = 32'h0; dwdata_v = 32'h0; dwen_v = 4'b0000;
    inst_req = 1'b0; inst_addr = 32'h0; data_req = 1'b0; data_wen = 4'b0000;
    data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset inst_ok", 32'(inst_ok), 32'd0);
    chk("reset data_ok", 32'(data_ok), 32'd0);
    chk("reset bus_err", 32'(bus_err), 32'd0);
    chk("reset mem_wr", 32'(mem_wr), 32'd0);
    chk("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset inst_rdata", inst_rdata, 32'd0);
    chk("reset data_rdata", data_rdata, 32'd0);
    chk("reset stall idle", 32'(stall), 32'd0);
    inst_req = 1'b1; #1;
    chk("reset stall formula", 32'(stall), 32'd1);
    inst_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run(1); mon_en = 1'b1;

    // single fetch, zero-wait memory
    fix_a = 0; fix_d = 0; rd_fix_en = 1'b1; rd_fix = 32'h3C1D_0000;
    req_inst(32'hBFC0_0000);
    wait_quiet();
    chk("fetch inst_rdata", inst_rdata, 32'h3C1D_0000);

    // store: strobes pass through, data_rdata untouched
    rd_fix = 32'h1234_5678;
    req_data(4'b0011, 32'h0000_0104, 32'hAABB_CCDD);
    wait_quiet();
    chk("store keeps data_rdata", data_rdata, 32'h0000_0000);

    // starvation guard: data held high, fetch pending from the same cycle
    rd_fix_en = 1'b0; obs_q.delete(); exp_seq = 5'b01111;
    rand_mode = 1'b1; p_d = 100; p_i = 0;
    req_data(4'b0000, 32'h0000_0200, 32'h0);
    req_inst(32'hBFC0_0004);
    begin
      int k = 0;
      while (i_busy && k < 200) begin run(1); k++; end
      if (k >= 200) chk("starve inst never served", 32'(i_busy), 32'd0);
    end
    for (int k = 0; k < 5; k++) begin
      if (k < obs_q.size()) chk($sformatf("starve grant order %0d", k), 32'(obs_q[k]), 32'(exp_seq[k]));
      else chk("starve grant count", 32'(obs_q.size()), 32'd5);
    end
    p_d = 0;
    wait_quiet();
    rand_mode = 1'b0;

    // slow memory: addr_ok after 3 cycles, data_ok after 5 more
    fix_a = 3; fix_d = 5;
    req_data(4'b0000, 32'h0000_0300, 32'h0);
    wait_quiet();

    // timeout: data phase never completes, late data_ok is ignored
    fix_a = 0; fix_d = 1000;
    req_data(4'b0000, 32'h0000_0400, 32'h0);
    wait_quiet();

    // reset during the data phase, then a normal fetch
    fix_a = 0; fix_d = 6;
    req_inst(32'hBFC0_0100);
    run(4);
    #2; mon_en = 1'b0; rst_n = 1'b0;
    #1;
    chk("mid reset mem_req", 32'(mem_req), 32'd0);
    chk("mid reset inst_ok", 32'(inst_ok), 32'd0);
    chk("mid reset bus_err", 32'(bus_err), 32'd0);
    chk("mid reset inst_rdata", inst_rdata, 32'd0);
    model_clear();
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    run(1); mon_en = 1'b1;
    fix_a = 0; fix_d = 0; rd_fix_en = 1'b1; rd_fix = 32'hCAFE_F00D;
    req_inst(32'hBFC0_0000);
    wait_quiet();
    chk("post reset fetch", inst_rdata, 32'hCAFE_F00D);

    // randomized traffic with flushes and handshake noise
    rd_fix_en = 1'b0; fix_a = -1; fix_d = -1; max_a = 4; max_d = 5;
    rand_mode = 1'b1; p_i = 40; p_d = 50; p_flush = 10; p_noise = 20;
    run(3000);
    p_i = 0; p_d = 0; p_flush = 0;
    wait_quiet();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
